// File: rtl/sobel_edge_stream.sv
// 3x3 Sobel edge stage with valid/ready backpressure, per-pixel mode/threshold and sof tagging.
// Optional per-frame edge counter on o_frame_edges is enabled by defining SOBEL_EDGE_COUNT_EN.
`timescale 1ns/1ps
module sobel_edge_stream #(
    parameter int DATA_W     = 8,
    parameter int MAG2_W     = 2*DATA_W+6,
    parameter int CNT_W      = 20,
    parameter int DEF_THRESH = 5000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [9*DATA_W-1:0] i_pixel_data,
    input  logic                i_pixel_data_valid,
    output logic                o_pixel_ready,
    input  logic                i_sof,
    input  logic [1:0]          i_mode,
    input  logic [MAG2_W-1:0]   i_threshold,
    output logic [DATA_W-1:0]   o_convolved_data,
    output logic                o_convolved_data_valid,
    input  logic                i_convolved_data_ready,
    output logic                o_sof,
    output logic [CNT_W-1:0]    o_frame_edges
);
    localparam int STAGES = 3;
    localparam int GW     = DATA_W + 4;
    localparam int AW     = DATA_W + 3;
    localparam int KX [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    localparam int KY [9] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};

    typedef logic signed [GW-1:0] grad_t;

    logic              en;
    logic [STAGES:0]   vld_pipe;

    assign en                     = !vld_pipe[STAGES] || i_convolved_data_ready;
    assign o_pixel_ready          = en;
    assign o_convolved_data_valid = vld_pipe[STAGES];

    function automatic grad_t tap_w(input logic [DATA_W-1:0] p, input int w);
        grad_t s;
        s = signed'({4'b0000, p});
        case (w)
            1:       return s;
            -1:      return -s;
            2:       return s <<< 1;
            -2:      return -(s <<< 1);
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [AW:0] v);
        return (|v[AW:DATA_W]) ? '1 : v[DATA_W-1:0];
    endfunction

    grad_t             px [9];
    grad_t             py [9];
    grad_t             gx, gy, gx_sum, gy_sum;
    logic [AW-1:0]     ax, ay, ax_n, ay_n;
    logic [MAG2_W-1:0] mag2, mag2_n;
    logic [1:0]        mode_s1, mode_s2, mode_s3;
    logic [MAG2_W-1:0] thr_s1, thr_s2, thr_s3;
    logic              sof_s1, sof_s2, sof_s3;
    logic [AW:0]       sum_n;
    logic [DATA_W-1:0] res_n;
    logic              edge_n;

    always_comb begin
        gx_sum = '0;
        gy_sum = '0;
        for (int k = 0; k < 9; k++) begin
            gx_sum = gx_sum + px[k];
            gy_sum = gy_sum + py[k];
        end
    end

    // |G| always fits in AW bits, so the sign bit can be dropped after negation
    assign ax_n   = gx[GW-1] ? AW'(-gx) : AW'(gx);
    assign ay_n   = gy[GW-1] ? AW'(-gy) : AW'(gy);
    assign mag2_n = MAG2_W'(ax_n) * MAG2_W'(ax_n) + MAG2_W'(ay_n) * MAG2_W'(ay_n);

    assign sum_n  = {1'b0, ax} + {1'b0, ay};
    assign edge_n = mag2 > thr_s3;

    always_comb begin
        res_n = '0;
        case (mode_s3)
            2'd0: res_n = edge_n ? '1 : '0;
            2'd1: res_n = sat(sum_n);
            2'd2: res_n = sat({1'b0, ax});
            2'd3: res_n = sat({1'b0, ay});
            default: res_n = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            for (int k = 0; k < 9; k++) begin
                px[k] <= '0;
                py[k] <= '0;
            end
            gx <= '0;  gy <= '0;
            ax <= '0;  ay <= '0;  mag2 <= '0;
            mode_s1 <= '0;  mode_s2 <= '0;  mode_s3 <= '0;
            thr_s1 <= MAG2_W'(DEF_THRESH);
            thr_s2 <= MAG2_W'(DEF_THRESH);
            thr_s3 <= MAG2_W'(DEF_THRESH);
            sof_s1 <= 1'b0;  sof_s2 <= 1'b0;  sof_s3 <= 1'b0;
            o_convolved_data <= '0;
            o_sof            <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], i_pixel_data_valid};
            for (int k = 0; k < 9; k++) begin
                px[k] <= tap_w(i_pixel_data[k*DATA_W +: DATA_W], KX[k]);
                py[k] <= tap_w(i_pixel_data[k*DATA_W +: DATA_W], KY[k]);
            end
            mode_s1 <= i_mode;   thr_s1 <= i_threshold;  sof_s1 <= i_sof;
            gx <= gx_sum;        gy <= gy_sum;
            mode_s2 <= mode_s1;  thr_s2 <= thr_s1;       sof_s2 <= sof_s1;
            ax <= ax_n;          ay <= ay_n;             mag2 <= mag2_n;
            mode_s3 <= mode_s2;  thr_s3 <= thr_s2;       sof_s3 <= sof_s2;
            o_convolved_data <= res_n;
            o_sof            <= sof_s3;
        end
    end

`ifdef SOBEL_EDGE_COUNT_EN
    logic             edge_q;
    logic             seen_sof;
    logic [CNT_W-1:0] run_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            edge_q        <= 1'b0;
            seen_sof      <= 1'b0;
            run_cnt       <= '0;
            o_frame_edges <= '0;
        end else begin
            if (en)
                edge_q <= edge_n;
            if (o_convolved_data_valid && i_convolved_data_ready) begin
                // Edges seen before the first sof belong to no frame and are dropped
                if (o_sof) begin
                    o_frame_edges <= seen_sof ? run_cnt : '0;
                    run_cnt       <= CNT_W'(edge_q);
                    seen_sof      <= 1'b1;
                end else if (edge_q && run_cnt != '1) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
            end
        end
    end
`else
    assign o_frame_edges = '0;
`endif

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Parametrised successor of the 3x3 Sobel edge stage in the image pipeline.
- Takes a 3x3 window per cycle from the line-buffer stage and computes Gx/Gy.
- Output is selectable per pixel: binary threshold, clipped magnitude, |Gx| or |Gy|.
- Adds valid/ready backpressure, a runtime threshold, start-of-frame tagging and an optional per-frame edge counter.

Parameters:
- DATA_W, 8: pixel width in bits.
- MAG2_W, 2*DATA_W+6: width of Gx^2+Gy^2 and of the threshold.
- CNT_W, 20: edge counter width.
- DEF_THRESH, 5000: i_threshold value that tests use to match the legacy behaviour.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pixel_data  in  9*DATA_W  window; tap k = [k*DATA_W +: DATA_W], k=0..8 row-major, k=0 top-left.
- i_pixel_data_valid  in  1  window valid.
- o_pixel_ready  out  1  stage accepts window.
- i_sof  in  1  window is the first of a frame; qualified by the input transfer.
- i_mode  in  2  0=threshold, 1=min(|Gx|+|Gy|,max), 2=|Gx| clipped, 3=|Gy| clipped.
- i_threshold  in  MAG2_W  edge threshold on Gx^2+Gy^2.
- o_convolved_data  out  DATA_W  result pixel.
- o_convolved_data_valid  out  1  result valid.
- i_convolved_data_ready  in  1  downstream accepts.
- o_sof  out  1  sof tag aligned to o_convolved_data.
- o_frame_edges  out  CNT_W  edge count of the last completed frame.

Behaviour:
- Input transfer: i_pixel_data_valid && o_pixel_ready. Output transfer: o_convolved_data_valid && i_convolved_data_ready.
- Global enable: en = !o_convolved_data_valid || i_convolved_data_ready. o_pixel_ready = en, combinational.
- All pipeline registers and valid bits advance only when en=1. Bubbles propagate as valid=0.
- Kernels: Gx = [1 0 -1; 2 0 -2; 1 0 -1]; Gy = [1 2 1; 0 0 0; -1 -2 -1].
- Pixels are unsigned, zero-extended to signed. Gx/Gy are signed DATA_W+4. No overflow is possible.
- Pipeline, 4 enabled cycles from input transfer to o_convolved_data_valid:
  - S1: per-tap products; capture i_mode, i_threshold and i_sof with the pixel.
  - S2: sum to Gx, Gy.
  - S3: Gx^2+Gy^2 (MAG2_W unsigned) and |Gx|, |Gy|.
  - S4: mode select into the output register.
- Mode and threshold therefore apply per pixel to windows accepted on or after a change. In-flight pixels are unaffected.
- Mode 0: all-ones if mag2 > threshold, else 0. Strict greater-than, so mag2 == threshold gives 0.
- Modes 1-3: unsigned value; saturate to 2^DATA_W-1 if it exceeds that.
- Output hold: while o_convolved_data_valid=1 and i_convolved_data_ready=0, o_convolved_data, o_sof and the valid bit are held stable. No data loss, no reordering.
- Reset (asserted at any time, including mid-stream):
  - All valid bits, o_convolved_data, o_sof and o_frame_edges go to 0.
  - In-flight pixels are discarded.
  - o_pixel_ready = 1 after reset, since o_convolved_data_valid = 0.
- Throughput: 1 pixel per cycle when i_convolved_data_ready is held high.

Optional Feature:
- Macro: SOBEL_EDGE_COUNT_EN.
- Defined:
  - Internal running counter (CNT_W, saturating) increments on each output transfer whose mag2 > threshold, independent of mode.
  - On an output transfer with o_sof=1, o_frame_edges loads the running count (previous frame). The running counter then restarts at that pixel's edge bit (0 or 1).
  - The first sof after reset loads 0.
- Not defined: no counter logic; o_frame_edges is tied to 0.

Test Plan:
- Flat window, all taps 100, mode 0, threshold 5000 -> o_convolved_data=0x00 exactly 4 cycles after the input transfer.
- Left column 255, rest 0 -> Gx=1020, Gy=0; results per mode: mode 0 -> 0xFF; mode 1 -> 0xFF (saturated); mode 2 -> 0xFF; mode 3 -> 0x00.
- Threshold edge cases, threshold 5000, mode 0:
  - left column 20 -> mag2=6400 -> 0xFF.
  - left column 17 -> mag2=4624 -> 0x00.
  - threshold 6400 with left column 20 -> 0x00 (strict >).
- Backpressure: stream 8 distinct windows back-to-back with i_convolved_data_ready low for 3 cycles mid-stream.
  - o_pixel_ready drops while stalled.
  - All 8 results appear in order, no duplicates, and are held stable during the stall.
- Mode switch from 0 to 1 between consecutive windows -> earlier pixel uses mode 0, later pixel uses mode 1. Assert reset with 3 pixels in flight -> valid=0 next cycle, no stale output after release.
- With SOBEL_EDGE_COUNT_EN: frame A (sof, 5 windows, 3 above threshold), then sof of frame B (an edge pixel) -> o_frame_edges=3 on B's sof transfer, and the running count continues from 1.
